// File: rtl/i2s_master_transmitter_pkg.sv
// Shared audio definitions for the I2S transmit path: frame geometry, FSM states
// and a helper that locates the data-carrying bit positions inside a slot.
package i2s_master_transmitter_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_W     = $clog2(SLOT_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  // Sample bits occupy slot positions 1..width; position 0 is the I2S one-bit delay.
  function automatic logic in_data_window(input logic [BIT_CNT_W-1:0] pos,
                                          input int unsigned          width);
    int unsigned slot_pos;
    slot_pos = 32'(pos[SLOT_W-1:0]);
    return (slot_pos >= 1) && (slot_pos <= width);
  endfunction

endpackage

// File: rtl/i2s_master_transmitter_if.sv
// Sample-input and DAC-pin bundle of the I2S master transmitter.
interface i2s_master_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  l_data_en;
  logic                  r_data_en;
  logic [DATA_WIDTH-1:0] l_data;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  bclk;
  logic                  lrclk;
  logic                  s_data;

  modport master (
    input  l_data_en, r_data_en, l_data, r_data,
    output bclk, lrclk, s_data
  );

  modport slave (
    output l_data_en, r_data_en, l_data, r_data,
    input  bclk, lrclk, s_data
  );
endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock / word-select generator: divides clk into bclk, counts bit positions
// within the 64-bit frame and flags the clk cycles that commit a bclk falling edge.
module i2s_clk_gen
  import i2s_master_transmitter_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  output logic                 bclk,
  output logic                 lrclk,
  output logic [BIT_CNT_W-1:0] next_pos,
  output logic                 fall_edge,
  output logic                 frame_edge
);

  localparam int unsigned          DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV - 1);

  i2s_state_e           state;
  i2s_state_e           state_nxt;
  logic                 count_en;
  logic                 div_term;
  logic [DIV_W-1:0]     divider;
  logic [BIT_CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run)  state_nxt = RUN;
      RUN:     if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_en   = (state == RUN) && run;
    div_term   = count_en && (divider == DIV_LAST);
    fall_edge  = div_term && bclk;
    next_pos   = bit_cnt + BIT_CNT_W'(1);
    frame_edge = fall_edge && (next_pos == '0);
  end

  // Dropping run returns every counter to its idle value on the very next clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divider <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b1;
      bit_cnt <= '1;
    end else if (!run) begin
      divider <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b1;
      bit_cnt <= '1;
    end else if (div_term) begin
      divider <= '0;
      bclk    <= ~bclk;
      if (bclk) begin
        bit_cnt <= next_pos;
        lrclk   <= next_pos[BIT_CNT_W-1];
      end
    end else if (count_en) begin
      divider <= divider + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_master_transmitter.sv
// I2S bus-master transmitter: captures stereo PCM strobes, buffers one pending
// pair and serializes it MSB first. Define I2S_TX_HOLD_LAST_EN to repeat the
// last pair on underflow instead of sending silence.
module i2s_master_transmitter
  import i2s_master_transmitter_pkg::*;
#(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      clear_status,
  i2s_master_transmitter_if.master  bus,
  output logic                      frame_start,
  output logic                      underflow,
  output logic                      overrun
);

  logic                  bclk_q;
  logic                  lrclk_q;
  logic                  s_data_q;
  logic                  fall_edge;
  logic                  frame_edge;
  logic [BIT_CNT_W-1:0]  next_pos;

  logic [DATA_WIDTH-1:0] l_cap, r_cap;
  logic                  l_got, r_got;
  logic [DATA_WIDTH-1:0] pend_l, pend_r;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] tx_l, tx_r;
  logic [DATA_WIDTH-1:0] l_new, r_new;
  logic [DATA_WIDTH-1:0] load_l, load_r;
  logic                  pair_done;
  logic                  underflow_set;
  logic                  overrun_set;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [DATA_WIDTH-1:0] last_l, last_r;
`endif

  i2s_clk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .bclk      (bclk_q),
    .lrclk     (lrclk_q),
    .next_pos  (next_pos),
    .fall_edge (fall_edge),
    .frame_edge(frame_edge)
  );

  assign bus.bclk   = bclk_q;
  assign bus.lrclk  = lrclk_q;
  assign bus.s_data = s_data_q;

  // A strobe arriving in the completing cycle is merged straight into the pair.
  always_comb begin
    pair_done     = run && (l_got || bus.l_data_en) && (r_got || bus.r_data_en);
    l_new         = bus.l_data_en ? bus.l_data : l_cap;
    r_new         = bus.r_data_en ? bus.r_data : r_cap;
    underflow_set = frame_edge && !pend_valid;
    overrun_set   = pair_done && pend_valid && !frame_edge;
  end

  always_comb begin
    load_l = pend_l;
    load_r = pend_r;
    if (!pend_valid) begin
`ifdef I2S_TX_HOLD_LAST_EN
      load_l = last_l;
      load_r = last_r;
`else
      load_l = '0;
      load_r = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_cap      <= '0;
      r_cap      <= '0;
      l_got      <= 1'b0;
      r_got      <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
    end else if (!run) begin
      l_cap      <= '0;
      r_cap      <= '0;
      l_got      <= 1'b0;
      r_got      <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
    end else if (pair_done) begin
      // Frame load reads the old pending pair in this same cycle.
      l_got      <= 1'b0;
      r_got      <= 1'b0;
      pend_l     <= l_new;
      pend_r     <= r_new;
      pend_valid <= 1'b1;
    end else begin
      if (bus.l_data_en) begin
        l_cap <= bus.l_data;
        l_got <= 1'b1;
      end
      if (bus.r_data_en) begin
        r_cap <= bus.r_data;
        r_got <= 1'b1;
      end
      if (frame_edge) pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_data_q    <= 1'b0;
      frame_start <= 1'b0;
      tx_l        <= '0;
      tx_r        <= '0;
    end else if (!run) begin
      s_data_q    <= 1'b0;
      frame_start <= 1'b0;
      tx_l        <= '0;
      tx_r        <= '0;
    end else begin
      frame_start <= frame_edge;
      if (frame_edge) begin
        s_data_q <= 1'b0;
        tx_l     <= load_l;
        tx_r     <= load_r;
      end else if (fall_edge) begin
        if (in_data_window(next_pos, DATA_WIDTH)) begin
          if (next_pos[BIT_CNT_W-1]) begin
            s_data_q <= tx_r[DATA_WIDTH-1];
            tx_r     <= tx_r << 1;
          end else begin
            s_data_q <= tx_l[DATA_WIDTH-1];
            tx_l     <= tx_l << 1;
          end
        end else begin
          s_data_q <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_l <= '0;
      last_r <= '0;
    end else if (!run) begin
      last_l <= '0;
      last_r <= '0;
    end else if (frame_edge) begin
      last_l <= load_l;
      last_r <= load_r;
    end
  end
`endif

  // Flags survive IDLE; only reset or clear_status drops them, and a set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (underflow_set)     underflow <= 1'b1;
      else if (clear_status) underflow <= 1'b0;
      if (overrun_set)       overrun   <= 1'b1;
      else if (clear_status) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_master_transmitter.sv
// Self-checking bench for i2s_master_transmitter: frame-timing model plus literal
// pins for frame contents, flags, run/rerun timing and asynchronous reset.
module tb_i2s_master_transmitter;

  localparam int unsigned D          = 2;
  localparam int unsigned DW         = 24;
  localparam int unsigned FRAME_CLKS = 128 * D;

  logic clk          = 1'b0;
  logic reset_n      = 1'b1;
  logic run          = 1'b0;
  logic clear_status = 1'b0;
  logic frame_start, underflow, overrun;

  i2s_master_transmitter_if #(.DATA_WIDTH(DW)) bus ();

  i2s_master_transmitter #(
    .BCLK_DIV  (D),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .clear_status(clear_status),
    .bus         (bus),
    .frame_start (frame_start),
    .underflow   (underflow),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_active = 1'b0;
  int unsigned     m_t      = 0;
  logic [DW-1:0]   m_cap_l = '0, m_cap_r = '0, m_pend_l = '0, m_pend_r = '0;
  logic [DW-1:0]   m_fr_l = '0, m_fr_r = '0, m_last_l = '0, m_last_r = '0;
  bit              m_got_l = 1'b0, m_got_r = 1'b0, m_pend_v = 1'b0;
  bit              m_uf = 1'b0, m_ov = 1'b0, m_uf_set, m_ov_set, m_load, m_done;

  task m_clear_data;
    m_cap_l = '0; m_cap_r = '0; m_pend_l = '0; m_pend_r = '0;
    m_fr_l = '0; m_fr_r = '0; m_last_l = '0; m_last_r = '0;
    m_got_l = 1'b0; m_got_r = 1'b0; m_pend_v = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_clear_data();
      m_uf = 1'b0;
      m_ov = 1'b0;
    end else begin
      m_uf_set = 1'b0;
      m_ov_set = 1'b0;
      if (!run) begin
        m_active = 1'b0;
        m_t      = 0;
        m_clear_data();
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_t      = 0;
        end else begin
          m_t++;
        end
        // A frame begins on every 64th bclk fall; fall number n happens at t = n*2D.
        m_load = (m_t > 0) && (m_t % (2 * D) == 0) && ((m_t / (2 * D) - 1) % 64 == 0);
        if (m_load) begin
          if (m_pend_v) begin
            m_fr_l = m_pend_l;
            m_fr_r = m_pend_r;
          end else begin
            m_uf_set = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
            m_fr_l = m_last_l;
            m_fr_r = m_last_r;
`else
            m_fr_l = '0;
            m_fr_r = '0;
`endif
          end
          m_last_l = m_fr_l;
          m_last_r = m_fr_r;
        end
        m_done = (m_got_l || bus.l_data_en) && (m_got_r || bus.r_data_en);
        if (m_done) begin
          if (m_pend_v && !m_load) m_ov_set = 1'b1;
          m_pend_l = bus.l_data_en ? bus.l_data : m_cap_l;
          m_pend_r = bus.r_data_en ? bus.r_data : m_cap_r;
          m_pend_v = 1'b1;
          m_got_l  = 1'b0;
          m_got_r  = 1'b0;
        end else begin
          if (bus.l_data_en) begin m_cap_l = bus.l_data; m_got_l = 1'b1; end
          if (bus.r_data_en) begin m_cap_r = bus.r_data; m_got_r = 1'b1; end
          if (m_load) m_pend_v = 1'b0;
        end
      end
      if (m_uf_set)          m_uf = 1'b1;
      else if (clear_status) m_uf = 1'b0;
      if (m_ov_set)          m_ov = 1'b1;
      else if (clear_status) m_ov = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic        e_bclk, e_lr, e_s, e_fs;
  int unsigned e_bit, e_pos;
  logic [DW-1:0] e_word;

  always @(negedge clk) begin
    e_bclk = 1'b0; e_lr = 1'b1; e_s = 1'b0; e_fs = 1'b0;
    if (m_active) begin
      e_bclk = ((m_t / D) % 2) == 1;
      e_bit  = (m_t / (2 * D) + 63) % 64;
      e_lr   = (e_bit >= 32);
      e_fs   = (m_t > 0) && (m_t % (2 * D) == 0) && (e_bit == 0);
      e_pos  = e_bit % 32;
      e_word = (e_bit < 32) ? m_fr_l : m_fr_r;
      e_s    = (e_pos >= 1 && e_pos <= DW) ? e_word[DW - e_pos] : 1'b0;
    end
    check("m_bclk",        bus.bclk,    e_bclk);
    check("m_lrclk",       bus.lrclk,   e_lr);
    check("m_s_data",      bus.s_data,  e_s);
    check("m_frame_start", frame_start, e_fs);
    check("m_underflow",   underflow,   m_uf);
    check("m_overrun",     overrun,     m_ov);
  end

  // ---------------- directed helpers ----------------
  function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
  endfunction

  task automatic wait_fs(input string name);
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < int'(FRAME_CLKS) + 16) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_start timeout got 0 expected 1", name);
    end
  endtask

  // Called on a frame_start negedge; returns on the next one.
  task automatic collect_frame(output logic [63:0] bits);
    for (int k = 0; k < 64; k++) begin
      bits[63-k] = bus.s_data;
      repeat (2 * D) @(negedge clk);
    end
  endtask

  task automatic drive_pair(input logic l_en, input logic [23:0] l, input logic r_en, input logic [23:0] r);
    bus.l_data_en = l_en;
    bus.l_data    = l;
    bus.r_data_en = r_en;
    bus.r_data    = r;
  endtask

  task automatic measure_period(output int p);
    int n = 0;
    p = 0;
    while (bus.bclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    while (bus.bclk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    do begin @(negedge clk); p++; end while (bus.bclk !== 1'b0 && p < 20);
    while (bus.bclk !== 1'b1 && p < 20) begin @(negedge clk); p++; end
  endtask

  logic [63:0] got_bits;
  logic [63:0] exp_hold;
  int          period, cnt;

  initial begin
    drive_pair(1'b0, '0, 1'b0, '0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bclk", bus.bclk, 1'b0);
    check("rst_lrclk", bus.lrclk, 1'b1);
    check("rst_s_data", bus.s_data, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // One pair before the first frame.
    run = 1'b1;
    drive_pair(1'b1, 24'hA5A5A5, 1'b1, 24'h5A5A5A);
    @(negedge clk);
    drive_pair(1'b0, '0, 1'b0, '0);
    wait_fs("first_frame");
    collect_frame(got_bits);
    check("frame_a5_5a", got_bits, frame_bits(24'hA5A5A5, 24'h5A5A5A));
    check("underflow_no_pair", underflow, 1'b1);
    collect_frame(got_bits);
`ifdef I2S_TX_HOLD_LAST_EN
    exp_hold = frame_bits(24'hA5A5A5, 24'h5A5A5A);
`else
    exp_hold = 64'd0;
`endif
    check("underflow_frame_data", got_bits, exp_hold);

    measure_period(period);
    check("bclk_period", period, 2 * D);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    check("clear_underflow", underflow, 1'b0);

    // Two pairs inside one frame.
    wait_fs("overrun_frame");
    drive_pair(1'b1, 24'h000001, 1'b1, 24'h000002);
    @(negedge clk);
    drive_pair(1'b1, 24'h7FFFFF, 1'b1, 24'h800000);
    @(negedge clk);
    drive_pair(1'b0, '0, 1'b0, '0);
    check("overrun_set", overrun, 1'b1);
    wait_fs("overrun_next");
    collect_frame(got_bits);
    check("overrun_second_pair", got_bits, frame_bits(24'h7FFFFF, 24'h800000));

    // Completion on the frame-load clk: now on a frame_start negedge.
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    drive_pair(1'b1, 24'h123456, 1'b1, 24'h654321);
    @(negedge clk);
    drive_pair(1'b0, '0, 1'b0, '0);
    repeat (FRAME_CLKS - 3) @(negedge clk);
    drive_pair(1'b1, 24'h0F0F0F, 1'b1, 24'hF0F0F0);
    @(negedge clk);
    drive_pair(1'b0, '0, 1'b0, '0);
    check("sim_frame_start", frame_start, 1'b1);
    check("sim_overrun", overrun, 1'b0);
    collect_frame(got_bits);
    check("sim_old_pair", got_bits, frame_bits(24'h123456, 24'h654321));
    check("sim_underflow", underflow, 1'b0);
    collect_frame(got_bits);
    check("sim_new_pair", got_bits, frame_bits(24'h0F0F0F, 24'hF0F0F0));

    // Random strobes and clears against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_pair($urandom_range(0, 99) < 2, 24'($urandom), $urandom_range(0, 99) < 2, 24'($urandom));
      clear_status = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    drive_pair(1'b0, '0, 1'b0, '0);
    clear_status = 1'b0;

    // Drop run in the middle of bit 40.
    wait_fs("drop_frame");
    repeat (40 * 2 * D + D) @(negedge clk);
    check("bclk_before_drop", bus.bclk, 1'b1);
    run = 1'b0;
    @(negedge clk);
    check("drop_bclk", bus.bclk, 1'b0);
    check("drop_lrclk", bus.lrclk, 1'b1);
    check("drop_s_data", bus.s_data, 1'b0);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    run = 1'b1;
    // Edge 0 samples run; the frame-start edge is edge 2*D, seen on the next negedge.
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_start !== 1'b1 && cnt < 64);
    check("rerun_latency", cnt, 2 * D + 1);
    check("rerun_underflow", underflow, 1'b1);
    check("rerun_overrun", overrun, 1'b0);

    // Asynchronous reset mid-frame.
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_bclk", bus.bclk, 1'b0);
    check("arst_lrclk", bus.lrclk, 1'b1);
    check("arst_s_data", bus.s_data, 1'b0);
    check("arst_frame_start", frame_start, 1'b0);
    check("arst_underflow", underflow, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
